// File: rtl/bcd_key_entry.sv
// ---------------------------------------------------------------------------
// bcd_key_entry
//
// Purpose:
//   Keypad digit entry stage for the doorlock path. It debounces the raw
//   scanner code and accepts exactly one digit per press. The one-hot decode
//   of each accepted digit is registered. Accepted digits are shifted into a
//   DIGITS-deep BCD entry buffer. The block also flags non-BCD codes, buffer
//   overflow, and abandonment of a partial entry after inactivity.
//
// Parameters:
//   DIGITS          entry buffer depth in BCD digits (1..8)
//   DEBOUNCE_CYCLES consecutive stable samples needed for press and release
//   TIMEOUT_CYCLES  idle cycles after the last accept before a partial
//                   entry is discarded (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   key_code     raw BCD code from the scanner
//   key_down     raw level, high while any key is pressed
//   clear        single-cycle request to empty the entry buffer
//   onehot       registered one-hot decode of the last accepted valid digit
//   digit_stb    one-cycle pulse on every accepted press
//   bad_code     one-cycle pulse with digit_stb when the code is 10..15
//   entry        digit buffer; the newest digit is in nibble [3:0]
//   entry_count  number of digits held (0..DIGITS)
//   entry_full   entry_count == DIGITS
//   overflow     one-cycle pulse when a valid digit is dropped because full
//   timeout      one-cycle pulse when the timer discards a partial entry
// ---------------------------------------------------------------------------
module bcd_key_entry #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            key_code,
    input  logic                  key_down,
    input  logic                  clear,
    output logic [9:0]            onehot,
    output logic                  digit_stb,
    output logic                  bad_code,
    output logic [4*DIGITS-1:0]   entry,
    output logic [3:0]            entry_count,
    output logic                  entry_full,
    output logic                  overflow,
    output logic                  timeout
);

    // Debounce counter must hold values up to DEBOUNCE_CYCLES.
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    // Timeout counter must hold values up to TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES < 3) ? 1 : $clog2(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [3:0]    DEPTH    = 4'(DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [3:0]            code_latch_reg;
    // Set by reset: any key seen afterwards is treated as already held, so
    // a press that straddles reset must be released before a new accept.
    logic                  lock_reg;
    logic [TW-1:0]         tmr_reg;

    logic [9:0]            onehot_reg;
    logic                  digit_stb_reg;
    logic                  bad_code_reg;
    logic [4*DIGITS-1:0]   entry_reg;
    logic [3:0]            count_reg;
    logic                  overflow_reg;
    logic                  timeout_reg;

    // Combinational helpers derived from the current state.
    logic                  press_stable;
    logic                  accept;
    logic                  code_valid;
    logic                  full;
    logic [9:0]            decoded;
    logic [4*DIGITS-1:0]   entry_shifted;

    always_comb begin
        press_stable = key_down && (key_code == code_latch_reg);
        // Accept on the PRESS cycle that follows the DEBOUNCE_CYCLES-th
        // stable sample; the sample on that cycle must still be stable.
        accept       = (state_reg == PRESS) && press_stable && (cnt_reg >= DEB_LAST);
        code_valid   = (code_latch_reg <= 4'd9);
        full         = (count_reg == DEPTH);
    end

    // Ten-line decoder of the latched code; codes 10..15 decode to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_dec
            assign decoded[gi] = (code_latch_reg == 4'(gi));
        end
    endgenerate

    // Buffer contents after pushing the latched code into nibble 0.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_shift
            if (gi == 0) begin : g_newest
                assign entry_shifted[3:0] = code_latch_reg;
            end else begin : g_older
                assign entry_shifted[4*gi +: 4] = entry_reg[4*(gi-1) +: 4];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            code_latch_reg <= '0;
            lock_reg       <= 1'b1;
            tmr_reg        <= '0;
            onehot_reg     <= '0;
            digit_stb_reg  <= 1'b0;
            bad_code_reg   <= 1'b0;
            entry_reg      <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            digit_stb_reg <= accept;
            bad_code_reg  <= accept && !code_valid;
            overflow_reg  <= 1'b0;
            timeout_reg   <= 1'b0;

            // ---------------- debounce FSM ----------------
            case (state_reg)
                IDLE: begin
                    if (lock_reg) begin
                        // First visit after reset: a held key goes straight
                        // to HELD, otherwise the release is debounced.
                        if (key_down) begin
                            state_reg <= HELD;
                        end else begin
                            cnt_reg   <= CNT_ONE;
                            state_reg <= RELEASE;
                        end
                    end else if (key_down) begin
                        code_latch_reg <= key_code;
                        cnt_reg        <= CNT_ONE;
                        state_reg      <= PRESS;
                    end
                end
                PRESS: begin
                    if (!press_stable) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg >= DEB_LAST) begin
                        state_reg <= HELD;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                HELD: begin
                    // Code changes while held are ignored.
                    if (!key_down) begin
                        cnt_reg   <= CNT_ONE;
                        state_reg <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (key_down) begin
                        state_reg <= HELD;
                    end else if (cnt_reg >= DEB_LAST) begin
                        lock_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // ---------------- buffer and timer ----------------
            // Priority: clear > accept > timeout > counting.
            if (clear) begin
                entry_reg  <= '0;
                count_reg  <= '0;
                onehot_reg <= '0;
                tmr_reg    <= '0;
            end else if (accept) begin
                tmr_reg <= '0;
                if (code_valid) begin
                    onehot_reg <= decoded;
                    if (full) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        entry_reg <= entry_shifted;
                        count_reg <= count_reg + 4'd1;
                    end
                end else begin
                    onehot_reg <= '0;
                end
            end else if (count_reg == 4'd0) begin
                tmr_reg <= '0;
            end else if (tmr_reg == TMR_LAST) begin
                entry_reg   <= '0;
                count_reg   <= '0;
                onehot_reg  <= '0;
                timeout_reg <= 1'b1;
                tmr_reg     <= '0;
            end else begin
                tmr_reg <= tmr_reg + TMR_ONE;
            end
        end
    end

    assign onehot      = onehot_reg;
    assign digit_stb   = digit_stb_reg;
    assign bad_code    = bad_code_reg;
    assign entry       = entry_reg;
    assign entry_count = count_reg;
    assign entry_full  = (count_reg == DEPTH);
    assign overflow    = overflow_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_bcd_key_entry.sv
// ---------------------------------------------------------------------------
// tb_bcd_key_entry
//
// Directed bench for bcd_key_entry with DIGITS=4, DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=20. Inputs change 1 time unit after a rising edge. Outputs
// are read at that same point, so they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_bcd_key_entry;

    localparam int DIGITS = 4;
    localparam int DEB    = 4;
    localparam int TMO    = 20;

    logic                clk;
    logic                rst_n;
    logic [3:0]          key_code;
    logic                key_down;
    logic                clear;
    logic [9:0]          onehot;
    logic                digit_stb;
    logic                bad_code;
    logic [4*DIGITS-1:0] entry;
    logic [3:0]          entry_count;
    logic                entry_full;
    logic                overflow;
    logic                timeout;

    int checks = 0;
    int errors = 0;

    // Pulse tallies, sampled on the falling edge.
    int stb_total = 0;
    int ovf_total = 0;
    int bad_total = 0;
    int tmo_total = 0;

    bcd_key_entry #(
        .DIGITS          (DIGITS),
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .key_down    (key_down),
        .clear       (clear),
        .onehot      (onehot),
        .digit_stb   (digit_stb),
        .bad_code    (bad_code),
        .entry       (entry),
        .entry_count (entry_count),
        .entry_full  (entry_full),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (digit_stb === 1'b1) stb_total++;
        if (overflow  === 1'b1) ovf_total++;
        if (bad_code  === 1'b1) bad_total++;
        if (timeout   === 1'b1) tmo_total++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the key with the given code until digit_stb appears or the
    // budget expires. Returns the edge count starting from the first sample.
    task automatic press_key(input logic [3:0] code, output int edges, output bit got);
        key_code = code;
        key_down = 1'b1;
        got      = 1'b0;
        edges    = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (digit_stb === 1'b1) begin
                got   = 1'b1;
                edges = n;
                break;
            end
        end
        $display("press code=%0d stb=%0b edges=%0d onehot=%b entry=%h count=%0d bad=%0b ovf=%0b",
                 code, got, edges, onehot, entry, entry_count, bad_code, overflow);
    endtask

    task automatic release_key();
        key_down = 1'b0;
        repeat (8) step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        int  s0;
        int  edges;
        bit  got;
        rst_n    = 1'b0;
        key_down = 1'b1;
        key_code = 4'd5;
        clear    = 1'b0;
        repeat (3) step();
        checks++;
        if (onehot !== 10'd0) begin
            errors++; $display("FAIL reset_onehot got=%b want=0", onehot);
        end
        checks++;
        if (entry !== 16'h0000 || entry_count !== 4'd0) begin
            errors++; $display("FAIL reset_entry got=%h/%0d want=0000/0", entry, entry_count);
        end
        checks++;
        if ({digit_stb, bad_code, overflow, timeout, entry_full} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=00000",
                               {digit_stb, bad_code, overflow, timeout, entry_full});
        end
        s0 = stb_total;
        rst_n = 1'b1;
        repeat (12) step();
        $display("reset released with key held, stb seen=%0d count=%0d", stb_total - s0, entry_count);
        checks++;
        if (stb_total - s0 !== 0 || entry_count !== 4'd0 || onehot !== 10'd0) begin
            errors++; $display("FAIL held_through_reset stb=%0d count=%0d onehot=%b want 0/0/0",
                               stb_total - s0, entry_count, onehot);
        end
        key_down = 1'b0;
        repeat (8) step();
        press_key(4'd5, edges, got);
        checks++;
        if (!got || edges != DEB + 1) begin
            errors++; $display("FAIL repress_latency got=%0b/%0d want 1/%0d", got, edges, DEB + 1);
        end
        checks++;
        if (onehot !== 10'b0000100000 || entry !== 16'h0005 || entry_count !== 4'd1) begin
            errors++; $display("FAIL repress_value onehot=%b entry=%h count=%0d want 0000100000/0005/1",
                               onehot, entry, entry_count);
        end
        release_key();
    endtask

    task automatic test_bounce();
        int s0;
        int edges;
        bit got;
        pulse_clear();
        s0 = stb_total;
        key_code = 4'd7;
        key_down = 1'b1; step();
        key_down = 1'b1; step();
        key_down = 1'b0; step();
        key_down = 1'b1;
        got   = 1'b0;
        edges = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (digit_stb === 1'b1) begin
                got   = 1'b1;
                edges = n;
                break;
            end
        end
        $display("bounce press code=7 stb=%0b edges=%0d onehot=%b entry=%h count=%0d",
                 got, edges, onehot, entry, entry_count);
        checks++;
        if (!got || edges != 5) begin
            errors++; $display("FAIL bounce_latency got=%0b/%0d want 1/5", got, edges);
        end
        checks++;
        if (onehot !== 10'b0010000000 || entry[3:0] !== 4'd7 || entry_count !== 4'd1) begin
            errors++; $display("FAIL bounce_value onehot=%b nib=%h count=%0d want 0010000000/7/1",
                               onehot, entry[3:0], entry_count);
        end
        repeat (3) step();
        checks++;
        if (stb_total - s0 !== 1) begin
            errors++; $display("FAIL bounce_single_stb got=%0d want 1", stb_total - s0);
        end
        release_key();
    endtask

    task automatic test_fill_overflow();
        int o0;
        int edges;
        bit got;
        int missed;
        pulse_clear();
        missed = 0;
        for (int d = 1; d <= 4; d++) begin
            press_key(4'(d), edges, got);
            if (!got) missed++;
            release_key();
        end
        checks++;
        if (missed != 0 || entry !== 16'h1234 || entry_count !== 4'd4 || entry_full !== 1'b1) begin
            errors++; $display("FAIL fill missed=%0d entry=%h count=%0d full=%0b want 0/1234/4/1",
                               missed, entry, entry_count, entry_full);
        end
        o0 = ovf_total;
        press_key(4'd9, edges, got);
        checks++;
        if (!got || overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_pulse stb=%0b ovf=%0b want 1/1", got, overflow);
        end
        checks++;
        if (entry !== 16'h1234 || entry_count !== 4'd4 || onehot !== 10'b1000000000) begin
            errors++; $display("FAIL overflow_value entry=%h count=%0d onehot=%b want 1234/4/1000000000",
                               entry, entry_count, onehot);
        end
        release_key();
        checks++;
        if (ovf_total - o0 !== 1 || overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_width pulses=%0d now=%0b want 1/0", ovf_total - o0, overflow);
        end
    endtask

    task automatic test_bad_code();
        int b0;
        int edges;
        bit got;
        pulse_clear();
        press_key(4'd3, edges, got); release_key();
        press_key(4'd4, edges, got); release_key();
        checks++;
        if (entry !== 16'h0034 || entry_count !== 4'd2) begin
            errors++; $display("FAIL bad_setup entry=%h count=%0d want 0034/2", entry, entry_count);
        end
        b0 = bad_total;
        press_key(4'd12, edges, got);
        checks++;
        if ({digit_stb, bad_code} !== 2'b11) begin
            errors++; $display("FAIL bad_pulse got=%b want 11", {digit_stb, bad_code});
        end
        checks++;
        if (onehot !== 10'd0 || entry !== 16'h0034 || entry_count !== 4'd2 || overflow !== 1'b0) begin
            errors++; $display("FAIL bad_value onehot=%b entry=%h count=%0d ovf=%0b want 0/0034/2/0",
                               onehot, entry, entry_count, overflow);
        end
        release_key();
        checks++;
        if (bad_total - b0 !== 1) begin
            errors++; $display("FAIL bad_width pulses=%0d want 1", bad_total - b0);
        end
    endtask

    task automatic test_clear_collision();
        int edges;
        bit got;
        pulse_clear();
        press_key(4'd1, edges, got); release_key();
        press_key(4'd2, edges, got); release_key();
        checks++;
        if (entry !== 16'h0012 || entry_count !== 4'd2) begin
            errors++; $display("FAIL collide_setup entry=%h count=%0d want 0012/2", entry, entry_count);
        end
        key_code = 4'd6;
        key_down = 1'b1;
        got   = 1'b0;
        edges = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == DEB + 1) clear = 1'b1;
            step();
            clear = 1'b0;
            if (digit_stb === 1'b1) begin
                got   = 1'b1;
                edges = n;
                break;
            end
        end
        $display("collide press code=6 stb=%0b edges=%0d onehot=%b entry=%h count=%0d ovf=%0b",
                 got, edges, onehot, entry, entry_count, overflow);
        checks++;
        if (!got || edges != DEB + 1) begin
            errors++; $display("FAIL collide_stb got=%0b/%0d want 1/%0d", got, edges, DEB + 1);
        end
        checks++;
        if (entry !== 16'h0000 || entry_count !== 4'd0 || onehot !== 10'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL collide_value entry=%h count=%0d onehot=%b ovf=%0b want 0/0/0/0",
                               entry, entry_count, onehot, overflow);
        end
        release_key();
        checks++;
        if (entry_count !== 4'd0) begin
            errors++; $display("FAIL collide_after count=%0d want 0", entry_count);
        end
    endtask

    task automatic test_timeout();
        int  t0;
        int  tk;
        int  sk;
        bit  tmo_seen;
        int  edges;
        bit  got;
        // Idle after one digit: the timer must discard it.
        pulse_clear();
        press_key(4'd3, edges, got);
        key_down = 1'b0;
        t0 = tmo_total;
        tk = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (timeout === 1'b1) begin
                tk = k;
                break;
            end
        end
        $display("timeout after accept at edge %0d count=%0d entry=%h", tk, entry_count, entry);
        checks++;
        if (tk != TMO) begin
            errors++; $display("FAIL timeout_delay got=%0d want %0d", tk, TMO);
        end
        checks++;
        if (entry_count !== 4'd0 || entry !== 16'h0000 || onehot !== 10'd0) begin
            errors++; $display("FAIL timeout_value count=%0d entry=%h onehot=%b want 0/0000/0",
                               entry_count, entry, onehot);
        end
        step();
        checks++;
        if (timeout !== 1'b0 || tmo_total - t0 !== 1) begin
            errors++; $display("FAIL timeout_width now=%0b pulses=%0d want 0/1", timeout, tmo_total - t0);
        end

        // Second digit accepted 19 edges after the first: no timeout.
        pulse_clear();
        press_key(4'd3, edges, got);
        key_down = 1'b0;
        for (int k = 1; k <= 14; k++) step();
        key_code = 4'd8;
        key_down = 1'b1;
        sk       = 0;
        tmo_seen = 1'b0;
        for (int k = 15; k <= 26; k++) begin
            step();
            if (digit_stb === 1'b1) sk = k;
            if (timeout === 1'b1) tmo_seen = 1'b1;
        end
        $display("rescue press code=8 accepted at edge %0d tmo=%0b entry=%h count=%0d",
                 sk, tmo_seen, entry, entry_count);
        checks++;
        if (sk != 19) begin
            errors++; $display("FAIL rescue_edge got=%0d want 19", sk);
        end
        checks++;
        if (tmo_seen || entry_count !== 4'd2 || entry !== 16'h0038) begin
            errors++; $display("FAIL rescue_value tmo=%0b count=%0d entry=%h want 0/2/0038",
                               tmo_seen, entry_count, entry);
        end
        release_key();
    endtask

    initial begin
        rst_n    = 1'b0;
        key_code = 4'd0;
        key_down = 1'b0;
        clear    = 1'b0;
        test_reset();
        test_bounce();
        test_fill_overflow();
        test_bad_code();
        test_clear_collision();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_key_entry.md
Name: bcd_key_entry

Overview:
- Sequential, parametrised successor to the team's combinational 4-bit BCD-to-ten-line digit decoder used on the doorlock keypad path.
- Debounces a raw keypad code and accepts exactly one digit per press.
- Registers the one-hot decode of the accepted digit and shifts it into a DIGITS-deep entry buffer.
- Also flags non-BCD codes, buffer overflow and entry inactivity timeout. Sits between the keypad scanner and the password-compare logic.

Parameters:
- DIGITS, 4, depth of the entry buffer in BCD digits (range 1..8).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required for press and for release (≥1).
- TIMEOUT_CYCLES, 1000, idle cycles after the last accepted digit before a partial entry is discarded (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- key_code  in  4  raw BCD code from the scanner; bit0 is LSB.
- key_down  in  1  raw level; high while any key is pressed.
- clear  in  1  single-cycle request to empty the entry buffer.
- onehot  out  10  registered one-hot decode of the last accepted valid digit; bit n set for digit n.
- digit_stb  out  1  one-cycle pulse on each accepted press, valid or not.
- bad_code  out  1  one-cycle pulse, coincident with digit_stb, when the accepted code is 10..15.
- entry  out  4*DIGITS  buffer; the newest digit is in nibble [3:0], older digits shift toward the MSBs.
- entry_count  out  4  number of digits held, 0..DIGITS.
- entry_full  out  1  high when entry_count == DIGITS.
- overflow  out  1  one-cycle pulse when a valid digit is accepted while full; the digit is discarded.
- timeout  out  1  one-cycle pulse when a partial entry is discarded by the timer.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - all outputs and the buffer to 0;
  - FSM to IDLE;
  - debounce counter and timeout counter to 0.
- Reset mid-press drops the press. A key still held after reset must be released and debounced before another digit is accepted.
- FSM states:
  - IDLE: if key_down=1, latch key_code, counter=1, go to PRESS.
  - PRESS:
    - key_down=0 or key_code differs from the latch: return to IDLE with no accept.
    - Otherwise increment the counter.
    - When the counter reaches DEBOUNCE_CYCLES, accept and go to HELD.
    - With DEBOUNCE_CYCLES=1, accept on the first PRESS cycle.
  - HELD: key_down=0 sets counter=1 and moves to RELEASE. Code changes while held are ignored.
  - RELEASE:
    - key_down=1 returns to HELD.
    - Otherwise increment the counter; at DEBOUNCE_CYCLES go to IDLE.
- Latency: digit_stb, onehot, entry and entry_count update on the clk edge after the (DEBOUNCE_CYCLES)th consecutive stable sample. That is DEBOUNCE_CYCLES+1 edges after key_down rises.
- On accept with code 0..9:
  - onehot ← decode(code).
  - If not full: entry ← {entry[4*DIGITS-5:0], code} and entry_count+1.
  - If full: buffer unchanged and overflow pulses.
- On accept with code 10..15:
  - onehot ← 0 and bad_code pulses.
  - Buffer and count are unchanged.
- Clear:
  - entry, entry_count and onehot go to 0 on the next edge.
  - If clear coincides with an accept, clear wins: no digit is stored and onehot stays 0. digit_stb and bad_code still pulse; overflow does not.
- Timeout counter:
  - Reset to 0 on any accept, clear or whenever entry_count==0; otherwise increments.
  - On reaching TIMEOUT_CYCLES-1 with entry_count>0, the next edge clears entry, entry_count and onehot, pulses timeout and resets the counter.
  - A coincident accept takes priority: the counter restarts and no timeout occurs.
- All pulse outputs are high for exactly one cycle.
- entry_full is combinational from entry_count.

Test Plan:
- Reset and idle check (DEBOUNCE_CYCLES=4): hold rst_n=0 for 3 cycles with key_down=1, key_code=5, then release reset with the key still held. Required: all outputs 0 until key_down falls and then re-presses for 4 stable cycles.
- Bounce rejection: key_down toggles 1,1,0,1,1,1,1 with code 7. Required: exactly one digit_stb, 5 edges after the final rise; onehot=10'b0010000000; entry[3:0]=7; entry_count=1.
- Buffer fill and overflow (DIGITS=4): press digits 1,2,3,4, then 9. Required: entry=16'h1234, entry_full=1, then overflow pulse with entry still 16'h1234 and onehot=bit 9.
- Bad code: press code 12 with entry=16'h0034. Required: digit_stb and bad_code pulse together, onehot=0, entry and count unchanged.
- Clear collision: assert clear on the same edge as the accept of digit 6 with count=2. Required: entry=0, count=0, onehot=0, digit_stb=1, no overflow.
- Timeout (TIMEOUT_CYCLES=20): accept digit 3, then go idle. Required: timeout pulses 20 cycles after that accept and entry_count returns to 0. A second digit accepted at cycle 19 prevents the timeout and leaves entry_count=2.
